// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1:4 demux dispatch controller.
package demux_pkg;

    localparam int N_OUT = 4;
    localparam int SEL_W = 2;

    // IDLE: nothing held. HOLD: one word held and offered on out_valid[sel].
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Expand a 2-bit channel select into a one-hot channel valid vector.
    function automatic logic [3:0] onehot4(input logic [SEL_W-1:0] sel);
        logic [3:0] v;
        v = 4'b0000;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin picker over four channels: first set bit of mask at or after ptr, wrapping 3->0.
module rr_pick4
    import demux_pkg::*;
(
    input  logic [3:0]       mask,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [7:0]       dbl;
    logic [3:0]       rot;
    logic [SEL_W-1:0] off;

    // Rotate so ptr sits at bit 0, priority-encode the lowest set bit, then rotate back.
    always_comb begin
        dbl = {mask, mask};
        rot = dbl[ptr +: 4];
        off = '0;
        for (int i = 3; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
        found = |rot;
        idx   = ptr + off;
    end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Sequencing controller for a 1:4 demux: holds one word and steers it to an explicit or
// round-robin channel, with per-channel backpressure and a drop pulse for disabled targets.
//
// Handshake: a word moves on any interface in a cycle where valid and ready are both high at the
// rising clock edge. Valid, once raised on an output channel, stays high with stable data and
// select until that channel's ready is seen; ready never depends on valid on the same interface.
module demux_dispatch_ctrl
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_dest,
    input  logic              in_dest_en,
    input  logic [N_OUT-1:0]  ch_en,
    output logic [N_OUT-1:0]  out_valid,
    input  logic [N_OUT-1:0]  out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        sel,
    output logic              drop,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [SEL_W-1:0]  sel_q,   sel_d;
    logic [SEL_W-1:0]  rr_q,    rr_d;
    logic [N_OUT-1:0]  valid_q, valid_d;
    logic              drop_q,  drop_d;

    logic [SEL_W-1:0]  rr_idx;
    logic              rr_found;
    logic [SEL_W-1:0]  target;
    logic              target_ok;
    logic              out_xfer;
    logic              in_rdy;
    logic              in_xfer;

    rr_pick4 u_pick (
        .mask  (ch_en),
        .ptr   (rr_q),
        .idx   (rr_idx),
        .found (rr_found)
    );

    // Target resolution and handshake qualifiers for the current cycle.
    always_comb begin
        target    = in_dest_en ? in_dest : rr_idx;
        target_ok = in_dest_en ? ch_en[in_dest] : rr_found;
        out_xfer  = (state_q == ST_HOLD) & out_ready[sel_q];
        // Round-robin with an empty mask has nowhere to go, so refuse the word outright.
        in_rdy    = ((state_q == ST_IDLE) | out_xfer) & (in_dest_en | rr_found);
        in_xfer   = in_valid & in_rdy;
    end

    // Next-state logic: retire the held word on out_xfer, then load any newly accepted word.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        rr_d    = rr_q;
        drop_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_HOLD: begin
                if (out_xfer) begin
                    state_d = ST_IDLE;
                    valid_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = '0;
            end
        endcase

        if (in_xfer) begin
            if (target_ok) begin
                // Same-cycle retire and load keeps HOLD: no idle bubble between words.
                state_d = ST_HOLD;
                data_d  = in_data;
                sel_d   = target;
                valid_d = onehot4(target);
                if (!in_dest_en) begin
                    rr_d = target + SEL_W'(1);
                end
            end else begin
                // Explicit destination is disabled: swallow the word and flag it.
                drop_d = 1'b1;
            end
        end
    end

    // State, holding register, round-robin pointer and drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= '0;
            rr_q    <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
            drop_q  <= drop_d;
        end
    end

    assign in_ready  = in_rdy;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign sel       = sel_q;
    assign drop      = drop_q;
    assign busy      = (state_q == ST_HOLD);

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench for demux_dispatch_ctrl: scoreboard of {sel,data} per accepted word,
// popped by a monitor on every observed output transfer, plus directed checks.
module tb_demux_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [1:0] in_dest = '0;
  logic       in_dest_en = 1'b0;
  logic [3:0] ch_en = 4'b1111;
  logic [3:0] out_valid;
  logic [3:0] out_ready = 4'b1111;
  logic [7:0] out_data;
  logic [1:0] sel;
  logic       drop;
  logic       busy;

  int total = 0;
  int bad = 0;
  int drop_cnt = 0;
  logic [9:0] exp_q[$];

  demux_dispatch_ctrl #(.DATA_W(8), .N_OUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .in_dest_en (in_dest_en),
    .ch_en      (ch_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .sel        (sel),
    .drop       (drop),
    .busy       (busy)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // monitor: every output transfer must match the oldest expected word
  always @(negedge clk) begin
    if (rst_n) begin
      if (drop) drop_cnt++;
      if ((out_valid & out_ready) != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {28'd0, out_valid}, 32'd0);
        end else begin
          logic [9:0] e;
          logic [3:0] oh;
          e = exp_q.pop_front();
          oh = 4'b0001 << e[9:8];
          check("out_sel", {30'd0, sel}, {30'd0, e[9:8]});
          check("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
          check("out_onehot", {28'd0, out_valid}, {28'd0, oh});
        end
      end
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("rst_valid", {28'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_sel", {30'd0, sel}, 32'd0);
    check("rst_drop", {31'd0, drop}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // drive one word; returns how many cycles in_ready was low before acceptance
  task automatic send(input logic [7:0] d, input logic [1:0] dst, input logic de,
                      input logic [1:0] esel, input logic push, output int waits);
    in_valid = 1'b1;
    in_data = d;
    in_dest = dst;
    in_dest_en = de;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      if (push) exp_q.push_back({esel, d});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    logic [1:0] sel_tab1[6];
    logic [1:0] sel_tab3[4];
    sel_tab1 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    sel_tab3 = '{2'd1, 2'd3, 2'd1, 2'd3};

    // 1: round-robin stream, full enable, always ready
    do_reset();
    ch_en = 4'b1111;
    out_ready = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      send(8'hA0 + 8'(i), 2'($urandom_range(0, 3)), 1'b0, sel_tab1[i], 1'b1, w);
      check("t1_b2b_wait", w, 32'd0);
    end
    wait_idle();
    check("t1_drain", exp_q.size(), 32'd0);
    check("t1_no_drop", drop_cnt, 32'd0);

    // 2: explicit destination stalled for 3 cycles
    out_ready = 4'b1011;
    send(8'h5C, 2'd2, 1'b1, 2'd2, 1'b1, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_stall_valid", {28'd0, out_valid}, 32'h4);
      check("t2_stall_data", {24'd0, out_data}, 32'h5C);
      check("t2_stall_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 4'b1111;
    @(negedge clk);
    check("t2_last_valid", {28'd0, out_valid}, 32'h4);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t2_idle_busy", {31'd0, busy}, 32'd0);
    check("t2_idle_valid", {28'd0, out_valid}, 32'd0);
    check("t2_keep_sel", {30'd0, sel}, 32'd2);
    check("t2_keep_data", {24'd0, out_data}, 32'h5C);

    // 3: round-robin over a sparse mask, then an empty mask
    do_reset();
    ch_en = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      send(8'($urandom_range(0, 255)), 2'd0, 1'b0, sel_tab3[i], 1'b1, w);
    end
    wait_idle();
    ch_en = 4'b0000;
    in_valid = 1'b1;
    in_dest_en = 1'b0;
    in_data = 8'hEE;
    repeat (3) begin
      @(negedge clk);
      check("t3_empty_ready", {31'd0, in_ready}, 32'd0);
      check("t3_empty_valid", {28'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // 4: RR word moves pointer to 1, dest word to disabled channel is dropped
    ch_en = 4'b1101;
    send(8'h70, 2'd0, 1'b0, 2'd0, 1'b1, w);
    wait_idle();
    w = drop_cnt;
    send(8'h77, 2'd1, 1'b1, 2'd1, 1'b0, w);
    @(negedge clk);
    check("t4_drop_hi", {31'd0, drop}, 32'd1);
    check("t4_drop_valid", {28'd0, out_valid}, 32'd0);
    check("t4_drop_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t4_drop_lo", {31'd0, drop}, 32'd0);
    @(posedge clk);
    #1;
    ch_en = 4'b1111;
    send(8'h78, 2'd3, 1'b0, 2'd1, 1'b1, w);
    wait_idle();

    // 5: asynchronous reset while holding on channel 3
    out_ready = 4'b0111;
    send(8'h3C, 2'd3, 1'b1, 2'd3, 1'b0, w);
    @(negedge clk);
    check("t5_hold_valid", {28'd0, out_valid}, 32'h8);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_valid", {28'd0, out_valid}, 32'd0);
    check("t5_async_busy", {31'd0, busy}, 32'd0);
    check("t5_async_data", {24'd0, out_data}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    out_ready = 4'b1111;
    @(posedge clk);
    #1;
    send(8'h51, 2'd2, 1'b0, 2'd0, 1'b1, w);
    wait_idle();

    // 6: dest-mode word does not move the round-robin pointer
    do_reset();
    send(8'h61, 2'd2, 1'b0, 2'd0, 1'b1, w);
    send(8'h62, 2'd3, 1'b1, 2'd3, 1'b1, w);
    send(8'h63, 2'd0, 1'b0, 2'd1, 1'b1, w);
    wait_idle();
    check("final_drain", exp_q.size(), 32'd0);
    check("final_drop_cnt", drop_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute time limit
  initial begin
    #200000;
    check("global_timeout", 32'd0, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
